// File: rtl/proc_stream_sequencer_pkg.sv
// Shared constants, FSM encoding and a width helper for the stream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_stream_sequencer_pkg;

    localparam int DEF_DATA_W = 36;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_BX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Bits needed to hold values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/proc_stream_sequencer_arbiter.sv
// Priority search: lowest non-empty channel at or after from_i, plus none-left flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: nz_i (per-channel non-empty mask), from_i (search start, may be N_IN),
//        next_o (selected channel), none_o (no channel at or after from_i).
module seq_chan_arbiter #(
    parameter int N_IN = 6,
    parameter int CH_W = 4
) (
    input  logic [N_IN-1:0] nz_i,
    input  logic [CH_W:0]   from_i,
    output logic [CH_W:0]   next_o,
    output logic            none_o
);

    // Descending scan so the lowest qualifying channel is written last.
    always_comb begin
        next_o = '0;
        none_o = 1'b1;
        for (int c = N_IN - 1; c >= 0; c--) begin
            if (nz_i[c] && (c >= int'(from_i))) begin
                next_o = (CH_W + 1)'(c);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/proc_stream_sequencer.sv
// Per event, reads every valid entry from N_IN memories and merges them into one tagged stream.
// Latency: LAT cycles from read_en to valid; one word per cycle; done_pulse one cycle after last valid.
// Backpressure: en_proc low holds the read issue; reads already in flight still emerge.
// Ports: clk/reset (sync active-high), en_proc, start (event tag), number_in (per-channel counts),
//        read_add/read_en/input_data (memory side), output_data/output_chan/valid (stream),
//        done/done_pulse/truncated (event status).
module proc_stream_sequencer
    import proc_stream_sequencer_pkg::*;
#(
    parameter int N_IN      = 6,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BX_W      = DEF_BX_W,
    parameter int LAT       = 2,
    parameter int MAX_READS = 108,
    parameter int CH_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en_proc,
    input  logic [BX_W-1:0]               start,
    input  logic [N_IN*(ADDR_W+1)-1:0]    number_in,
    output logic [N_IN*(BX_W+ADDR_W)-1:0] read_add,
    output logic [N_IN-1:0]               read_en,
    input  logic [N_IN*DATA_W-1:0]        input_data,
    output logic [DATA_W-1:0]             output_data,
    output logic [CH_W-1:0]               output_chan,
    output logic                          valid,
    output logic [BX_W-1:0]               done,
    output logic                          done_pulse,
    output logic                          truncated
);

    localparam int CW   = ADDR_W + 1;
    localparam int AW   = BX_W + ADDR_W;
    localparam int RD_W = clog2(MAX_READS + 1);

    state_e                state_q;
    logic [BX_W-1:0]       start_q, tag_q, done_q;
    logic [CW-1:0]         cnt_q [N_IN];
    logic [CH_W:0]         chan_q;       // one extra bit so "past the last channel" is representable
    logic [CW-1:0]         idx_q;
    logic [RD_W-1:0]       reads_q;
    logic [N_IN-1:0]       read_en_q;
    logic [N_IN*AW-1:0]    read_add_q;
    logic [CH_W-1:0]       rd_ch_q;
    logic [LAT-1:0]        pipe_vld_q;
    logic [CH_W-1:0]       pipe_ch_q [LAT];
    logic                  done_pulse_q, trunc_q;

    logic [CW-1:0]         num_c [N_IN];
    logic [N_IN-1:0]       nz;
    logic [CH_W:0]         arb_ch;
    logic                  none_left;
    logic [CW-1:0]         cur_cnt, idx_d;
    logic [RD_W-1:0]       reads_d;
    logic                  last_of_ch, more_after, budget_hit, pend, evt;

    assign evt = (start != start_q);

    // Clamp incoming counts to the page depth.
    always_comb begin
        for (int c = 0; c < N_IN; c++) begin
            num_c[c] = number_in[c*CW +: CW];
            if (num_c[c] > CW'(2**ADDR_W)) num_c[c] = CW'(2**ADDR_W);
            nz[c] = (cnt_q[c] != '0);
        end
    end

    seq_chan_arbiter #(.N_IN(N_IN), .CH_W(CH_W)) u_arb (
        .nz_i   (nz),
        .from_i (chan_q),
        .next_o (arb_ch),
        .none_o (none_left)
    );

    always_comb begin
        cur_cnt    = '0;
        more_after = 1'b0;
        for (int c = 0; c < N_IN; c++) begin
            if (int'(arb_ch) == c) cur_cnt = cnt_q[c];
            if ((c > int'(arb_ch)) && nz[c]) more_after = 1'b1;
        end
        idx_d      = idx_q + CW'(1);
        reads_d    = reads_q + RD_W'(1);
        last_of_ch = (idx_d == cur_cnt);
        budget_hit = (reads_d == RD_W'(MAX_READS));
    end

    // Anything that will still produce a valid after the current cycle.
    always_comb begin
        pend = |read_en_q;
        for (int i = 0; i < LAT - 1; i++) pend = pend | pipe_vld_q[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= start;
            tag_q        <= '0;
            done_q       <= '0;
            chan_q       <= '0;
            idx_q        <= '0;
            reads_q      <= '0;
            read_en_q    <= '0;
            read_add_q   <= '0;
            rd_ch_q      <= '0;
            pipe_vld_q   <= '0;
            done_pulse_q <= 1'b0;
            trunc_q      <= 1'b0;
            for (int c = 0; c < N_IN; c++) cnt_q[c] <= '0;
            for (int i = 0; i < LAT; i++) pipe_ch_q[i] <= '0;
        end else begin
            read_en_q    <= '0;
            done_pulse_q <= 1'b0;
            trunc_q      <= 1'b0;
            start_q      <= start;

            pipe_vld_q[0] <= |read_en_q;
            pipe_ch_q[0]  <= rd_ch_q;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_ch_q[i]  <= pipe_ch_q[i-1];
            end

            case (state_q)
                SCAN: begin
                    if (none_left) begin
                        state_q <= DRAIN;
                    end else if (en_proc && !evt) begin
                        for (int c = 0; c < N_IN; c++) begin
                            read_en_q[c] <= (int'(arb_ch) == c);
                            if (int'(arb_ch) == c)
                                read_add_q[c*AW +: AW] <= {tag_q, idx_q[ADDR_W-1:0]};
                        end
                        rd_ch_q <= arb_ch[CH_W-1:0];
                        reads_q <= reads_d;
                        if (last_of_ch) begin
                            chan_q <= arb_ch + (CH_W + 1)'(1);
                            idx_q  <= '0;
                        end else begin
                            chan_q <= arb_ch;
                            idx_q  <= idx_d;
                        end
                        if (budget_hit) begin
                            state_q <= DRAIN;
                            trunc_q <= !last_of_ch || more_after;
                        end
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        done_q       <= tag_q;
                        done_pulse_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: ;
            endcase

            // New event; an unfinished one is aborted, but completion on this cycle wins.
            if (evt) begin
                if (state_q == SCAN || (state_q == DRAIN && pend)) begin
                    trunc_q      <= 1'b1;
                    done_q       <= tag_q;
                    done_pulse_q <= 1'b1;
                end
                tag_q   <= start;
                chan_q  <= '0;
                idx_q   <= '0;
                reads_q <= '0;
                state_q <= SCAN;
                for (int c = 0; c < N_IN; c++) cnt_q[c] <= num_c[c];
            end
        end
    end

    always_comb begin
        output_data = '0;
        for (int c = 0; c < N_IN; c++) begin
            if (pipe_vld_q[LAT-1] && (int'(pipe_ch_q[LAT-1]) == c))
                output_data = input_data[c*DATA_W +: DATA_W];
        end
    end

    assign output_chan = pipe_vld_q[LAT-1] ? pipe_ch_q[LAT-1] : '0;
    assign valid       = pipe_vld_q[LAT-1];
    assign read_en     = read_en_q;
    assign read_add    = read_add_q;
    assign done        = done_q;
    assign done_pulse  = done_pulse_q;
    assign truncated   = trunc_q;

endmodule
